// File: rtl/shift_sched_ctrl.sv
// shift_sched_ctrl
//   Two-requester round-robin arbiter in front of a shared right-shift
//   serializer. The winning requester's parallel word is captured and shifted
//   out LSB-first over a valid/ready serial port. At the end of each transfer
//   a done pulse is raised and the owner tag identifies who was served.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   req[1:0]   per-requester request (held until the matching gnt bit)
//   data0/1    requester parallel words
//   flush      synchronous abort of the current transfer / blocks arbitration
//   ser_ready  consumer accepts the current beat
//   gnt[1:0]   one-cycle one-hot pulse: that requester's word was captured
//   ser_out    current serial bit (shift register bit 0)
//   ser_valid  beat valid
//   busy       transfer in progress
//   owner      requester currently (or last) served
//   done       one-cycle pulse after the final beat is accepted
module shift_sched_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic             flush,
  input  logic             ser_ready,
  output logic [1:0]       gnt,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             owner,
  output logic             done
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] cnt;
  logic             rr;     // requester favoured when both request
  logic             win;    // arbitration winner this cycle
  logic             take;   // a grant happens on this edge
  logic             last;   // final beat is accepted on this edge

  // Round-robin pick: a lone requester wins outright, a tie goes to rr.
  always_comb begin
    win = 1'b0;
    if (req == 2'b11) win = rr;
    else              win = req[1];
  end

  assign take = (state == IDLE) && !flush && (req != 2'b00);
  assign last = (state == SHIFT) && !flush && ser_ready && (cnt == '0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (take) state_nxt = SHIFT;
      SHIFT: if (flush || last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered pulses. gnt/done default low so they only ever
  // last one cycle; they cannot coincide since gnt is set only from IDLE and
  // done only from SHIFT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg  <= '0;
      cnt   <= '0;
      rr    <= 1'b0;
      gnt   <= 2'b00;
      done  <= 1'b0;
      owner <= 1'b0;
    end else begin
      gnt  <= 2'b00;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            sreg  <= win ? data1 : data0;
            cnt   <= CNT_W'(WIDTH - 1);
            owner <= win;
            gnt   <= win ? 2'b10 : 2'b01;
            rr    <= ~win;
          end
        end
        SHIFT: begin
          if (flush) begin
            // Abort: drop the word, keep owner and rr untouched, no done.
            sreg <= '0;
            cnt  <= '0;
          end else if (ser_ready) begin
            sreg <= sreg >> 1;
            cnt  <= cnt - CNT_W'(1);
            if (cnt == '0) done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    ser_valid = (state == SHIFT);
    busy      = (state == SHIFT);
    ser_out   = sreg[0];
  end

endmodule

// File: tb/tb_shift_sched_ctrl.sv
module tb_shift_sched_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req;
  logic [WIDTH-1:0] data0, data1;
  logic             flush, ser_ready;
  logic [1:0]       gnt;
  logic             ser_out, ser_valid, busy, owner, done;

  int n_cmp = 0;
  int n_err = 0;

  shift_sched_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .req(req), .data0(data0), .data1(data1),
    .flush(flush), .ser_ready(ser_ready), .gnt(gnt), .ser_out(ser_out),
    .ser_valid(ser_valid), .busy(busy), .owner(owner), .done(done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: a transfer is a queue of bits --------
  bit       m_q[$];
  bit       m_busy, m_rr, m_owner, m_done;
  bit [1:0] m_gnt;

  task automatic model_reset();
    m_q.delete();
    m_busy = 0; m_rr = 0; m_owner = 0; m_done = 0; m_gnt = 2'b00;
  endtask

  task automatic model_step();
    int w;
    logic [WIDTH-1:0] d;
    m_gnt  = 2'b00;
    m_done = 0;
    if (!m_busy) begin
      if (!flush && req != 2'b00) begin
        if (req == 2'b11) w = int'(m_rr);
        else              w = req[1] ? 1 : 0;
        d = (w == 1) ? data1 : data0;
        for (int i = 0; i < WIDTH; i++) m_q.push_back(d[i]);
        m_owner = (w == 1);
        m_gnt   = (w == 1) ? 2'b10 : 2'b01;
        m_rr    = (w == 0);
        m_busy  = 1;
      end
    end else if (flush) begin
      m_q.delete();
      m_busy = 0;
    end else if (ser_ready) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        m_busy = 0;
        m_done = 1;
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic compare_model();
    chk("m_gnt",   32'(gnt),       32'(m_gnt));
    chk("m_valid", 32'(ser_valid), 32'(m_busy));
    chk("m_busy",  32'(busy),      32'(m_busy));
    chk("m_out",   32'(ser_out),   32'((m_busy && m_q.size() > 0) ? m_q[0] : 1'b0));
    chk("m_done",  32'(done),      32'(m_done));
    chk("m_owner", 32'(owner),     32'(m_owner));
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic wait_gnt(int budget, output logic [1:0] g);
    g = 2'b00;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (gnt != 2'b00) begin g = gnt; return; end
    end
    chk("wait_gnt_timeout", 32'd1, 32'd0);
  endtask

  typedef struct {
    logic [1:0] req;
    logic [7:0] d0;
    logic       ready;
    logic [1:0] e_gnt;
    logic       e_out, e_vld, e_done;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] g;
    logic [1:0] glist[4];
    logic [7:0] words[4];
    int  ng, nd, pos, cyc, gcyc, dcyc, beats, stall;
    bit  saw_done;

    // Single transfer of 8'hA5 from requester 0 (LSB first 1,0,1,0,0,1,0,1).
    tbl[0] = '{2'b01, 8'hA5, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{2'b00, 8'hA5, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{2'b00, 8'hA5, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{2'b00, 8'hA5, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{2'b00, 8'hA5, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{2'b00, 8'hA5, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{2'b00, 8'hA5, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{2'b00, 8'hA5, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{2'b00, 8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1};
    tbl[9] = '{2'b00, 8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; req = 2'b00; data0 = '0; data1 = '0; flush = 1'b0; ser_ready = 1'b1;
    model_reset();
    #2;
    chk("rst_gnt",   32'(gnt),       32'd0);
    chk("rst_valid", 32'(ser_valid), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_done",  32'(done),      32'd0);
    chk("rst_owner", 32'(owner),     32'd0);
    chk("rst_out",   32'(ser_out),   32'd0);
    @(negedge clk);
    reset = 1'b0;

    // ---- table-driven single transfer
    for (int i = 0; i < 10; i++) begin
      req = tbl[i].req; data0 = tbl[i].d0; ser_ready = tbl[i].ready;
      cycle();
      chk($sformatf("tbl%0d_gnt", i),  32'(gnt),       32'(tbl[i].e_gnt));
      chk($sformatf("tbl%0d_out", i),  32'(ser_out),   32'(tbl[i].e_out));
      chk($sformatf("tbl%0d_vld", i),  32'(ser_valid), 32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_done", i), 32'(done),      32'(tbl[i].e_done));
      chk($sformatf("tbl%0d_own", i),  32'(owner),     32'd0);
    end

    // ---- contention: req=11 held, grants must alternate
    do_reset();
    req = 2'b11; data0 = 8'h0F; data1 = 8'hF0; ser_ready = 1'b1;
    ng = 0; nd = 0; pos = 0;
    for (int i = 0; i < 60 && nd < 4; i++) begin
      cycle();
      if (gnt != 2'b00 && ng < 4) begin glist[ng] = gnt; words[ng] = '0; ng++; pos = 0; end
      if (done) nd++;
      if (nd == 4) req = 2'b00;
      if (ser_valid && ser_ready && ng > 0 && pos < WIDTH) begin
        words[ng-1][pos] = ser_out; pos++;
      end
    end
    chk("rr_grants", 32'(ng), 32'd4);
    chk("rr_dones",  32'(nd), 32'd4);
    for (int i = 0; i < 4 && i < ng; i++) begin
      chk($sformatf("rr_gnt%0d", i),  32'(glist[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("rr_word%0d", i), 32'(words[i]), (i % 2 == 0) ? 32'h0F : 32'hF0);
    end
    for (int i = 0; i < 3; i++) cycle();

    // ---- backpressure: 3 stall cycles after beat 2 of 8'h3C
    do_reset();
    req = 2'b10; data1 = 8'h3C; ser_ready = 1'b1;
    cyc = 0; gcyc = -1; dcyc = -1; beats = 0; stall = 3; words[0] = '0;
    for (int i = 0; i < 40 && dcyc < 0; i++) begin
      cycle(); cyc++;
      if (gnt != 2'b00) begin gcyc = cyc; req = 2'b00; end
      if (done) dcyc = cyc;
      if (beats == 2 && stall > 0) begin ser_ready = 1'b0; stall--; end
      else ser_ready = 1'b1;
      if (ser_valid && ser_ready && beats < WIDTH) begin
        words[0][beats] = ser_out; beats++;
      end
    end
    chk("bp_word",    32'(words[0]),    32'h3C);
    chk("bp_latency", 32'(dcyc - gcyc), 32'(WIDTH + 3));

    // ---- flush during beat 4
    do_reset();
    req = 2'b01; data0 = 8'h96; ser_ready = 1'b1;
    wait_gnt(5, g);
    req = 2'b00;
    for (int i = 0; i < 3; i++) cycle();   // beat 4 now presented
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("fl_valid", 32'(ser_valid), 32'd0);
    chk("fl_busy",  32'(busy),      32'd0);
    saw_done = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (done) saw_done = 1;
    end
    chk("fl_no_done", 32'(saw_done), 32'd0);
    req = 2'b11;
    wait_gnt(5, g);
    req = 2'b00;
    chk("fl_rr_gnt", 32'(g),     32'h2);
    chk("fl_owner",  32'(owner), 32'd1);
    for (int i = 0; i < 10; i++) cycle();

    // ---- async reset during beat 5
    do_reset();
    req = 2'b10; data1 = 8'h5A; ser_ready = 1'b1;
    wait_gnt(5, g);
    req = 2'b00;
    for (int i = 0; i < 4; i++) cycle();
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", 32'(ser_valid), 32'd0);
    chk("ar_busy",  32'(busy),      32'd0);
    chk("ar_gnt",   32'(gnt),       32'd0);
    chk("ar_done",  32'(done),      32'd0);
    chk("ar_owner", 32'(owner),     32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    req = 2'b10;
    cycle();
    chk("ar_regnt",  32'(gnt),   32'h2);
    chk("ar_reown",  32'(owner), 32'd1);
    req = 2'b00;

    // ---- randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle();
      for (int r = 0; r < 2; r++) begin
        if (req[r] && gnt[r]) req[r] = ($urandom % 2 == 0);
        else if (!req[r]) req[r] = ($urandom % 3 == 0);
        if (!req[r] || gnt[r]) begin
          if (r == 0) data0 = WIDTH'($urandom);
          else        data1 = WIDTH'($urandom);
        end
      end
      ser_ready = ($urandom % 4 != 0);
      flush     = ($urandom % 20 == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
